// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared encodings for the AXI burst memory slave: engine states, response
// codes, burst types and the widest legal beat size for a data width.
package axi_burst_mem_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_FETCH = 2'b01,
    R_DATA  = 2'b10
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  function automatic logic [2:0] max_size(input int data_w);
    return (data_w == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 bus bundle between the interconnect (master) and the burst memory slave.
interface axi_burst_mem_slave_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

endinterface

// File: rtl/axi_beat_addr_gen.sv
// Next-beat address for FIXED/INCR bursts plus legality of size/burst.
module axi_beat_addr_gen
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);
  localparam logic [2:0]        MAX_SIZE = max_size(DATA_W);
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] step_s;

  // INCR aligns down to the beat size before stepping; wraps modulo 2^ADDR_W
  always_comb begin
    step_s  = ONE << size;
    illegal = (size > MAX_SIZE) || (burst == BURST_WRAP) || (burst == BURST_RSVD);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = (addr & ~(step_s - ONE)) + step_s;
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 slave memory model: independent write and read engines that turn
// INCR/FIXED bursts into single-beat memory accesses, SLVERR on illegal requests.
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_burst_mem_slave_if.slave  s_axi,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int STRB_W = DATA_W / 8;

  w_state_t          w_state_r, w_next_s;
  logic [ID_W-1:0]   w_id_r;
  logic [ADDR_W-1:0] w_addr_r, w_gen_addr_s, w_next_addr_s;
  logic [7:0]        w_len_r, w_cnt_r;
  logic [2:0]        w_size_r, w_gen_size_s;
  logic [1:0]        w_burst_r, w_gen_burst_s;
  logic              w_err_r, w_illegal_s;

  r_state_t          r_state_r, r_next_s;
  logic [ID_W-1:0]   r_id_r;
  logic [ADDR_W-1:0] r_addr_r, r_gen_addr_s, r_next_addr_s;
  logic [7:0]        r_len_r, r_cnt_r;
  logic [2:0]        r_size_r, r_gen_size_s;
  logic [1:0]        r_burst_r, r_gen_burst_s;
  logic              r_err_r, r_illegal_s;

  // Generators see the incoming request while idle so legality is known at the handshake
  always_comb begin
    if (w_state_r == W_IDLE) begin
      w_gen_addr_s  = s_axi.aw_addr;
      w_gen_size_s  = s_axi.aw_size;
      w_gen_burst_s = s_axi.aw_burst;
    end else begin
      w_gen_addr_s  = w_addr_r;
      w_gen_size_s  = w_size_r;
      w_gen_burst_s = w_burst_r;
    end
    if (r_state_r == R_IDLE) begin
      r_gen_addr_s  = s_axi.ar_addr;
      r_gen_size_s  = s_axi.ar_size;
      r_gen_burst_s = s_axi.ar_burst;
    end else begin
      r_gen_addr_s  = r_addr_r;
      r_gen_size_s  = r_size_r;
      r_gen_burst_s = r_burst_r;
    end
  end

  axi_beat_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_gen (
    .addr(w_gen_addr_s), .size(w_gen_size_s), .burst(w_gen_burst_s),
    .next_addr(w_next_addr_s), .illegal(w_illegal_s)
  );

  axi_beat_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_r_gen (
    .addr(r_gen_addr_s), .size(r_gen_size_s), .burst(r_gen_burst_s),
    .next_addr(r_next_addr_s), .illegal(r_illegal_s)
  );

  // Engine state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
    end else begin
      w_state_r <= w_next_s;
      r_state_r <= r_next_s;
    end
  end

  // Write next-state and outputs
  always_comb begin
    w_next_s       = w_state_r;
    s_axi.aw_ready = 1'b0;
    s_axi.w_ready  = 1'b0;
    s_axi.b_valid  = 1'b0;
    s_axi.b_id     = {ID_W{1'b0}};
    s_axi.b_resp   = RESP_OKAY;
    mem_we         = 1'b0;
    mem_waddr      = {ADDR_W{1'b0}};
    mem_wdata      = {DATA_W{1'b0}};
    mem_wstrb      = {STRB_W{1'b0}};
    case (w_state_r)
      W_IDLE: begin
        s_axi.aw_ready = 1'b1;
        if (s_axi.aw_valid) w_next_s = W_DATA;
        else                w_next_s = W_IDLE;
      end
      W_DATA: begin
        s_axi.w_ready = 1'b1;
        if (s_axi.w_valid) begin
          if (!w_err_r) begin
            mem_we    = 1'b1;
            mem_waddr = w_addr_r;
            mem_wdata = s_axi.w_data;
            mem_wstrb = s_axi.w_strb;
          end else begin
            mem_we    = 1'b0;
          end
          if (s_axi.w_last) w_next_s = W_RESP;
          else              w_next_s = W_DATA;
        end else begin
          w_next_s = W_DATA;
        end
      end
      W_RESP: begin
        s_axi.b_valid = 1'b1;
        s_axi.b_id    = w_id_r;
        s_axi.b_resp  = w_err_r ? RESP_SLVERR : RESP_OKAY;
        if (s_axi.b_ready) w_next_s = W_IDLE;
        else               w_next_s = W_RESP;
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write request latch, beat counter and error tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_id_r    <= {ID_W{1'b0}};
      w_addr_r  <= {ADDR_W{1'b0}};
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'b00;
      w_err_r   <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: if (s_axi.aw_valid) begin
          w_id_r    <= s_axi.aw_id;
          w_addr_r  <= s_axi.aw_addr;
          w_len_r   <= s_axi.aw_len;
          w_size_r  <= s_axi.aw_size;
          w_burst_r <= s_axi.aw_burst;
          w_cnt_r   <= 8'd0;
          w_err_r   <= w_illegal_s;
        end
        W_DATA: if (s_axi.w_valid) begin
          w_addr_r <= w_next_addr_s;
          // counter holds on the last beat so len=255 never wraps
          if (!s_axi.w_last) w_cnt_r <= w_cnt_r + 8'd1;
          if (s_axi.w_last != (w_cnt_r == w_len_r)) w_err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read next-state and outputs
  always_comb begin
    r_next_s       = r_state_r;
    s_axi.ar_ready = 1'b0;
    s_axi.r_valid  = 1'b0;
    s_axi.r_id     = {ID_W{1'b0}};
    s_axi.r_data   = {DATA_W{1'b0}};
    s_axi.r_resp   = RESP_OKAY;
    s_axi.r_last   = 1'b0;
    mem_re         = 1'b0;
    mem_raddr      = {ADDR_W{1'b0}};
    case (r_state_r)
      R_IDLE: begin
        s_axi.ar_ready = 1'b1;
        if (s_axi.ar_valid) r_next_s = R_FETCH;
        else                r_next_s = R_IDLE;
      end
      R_FETCH: begin
        if (!r_err_r) begin
          mem_re    = 1'b1;
          mem_raddr = r_addr_r;
        end else begin
          mem_re    = 1'b0;
        end
        r_next_s = R_DATA;
      end
      R_DATA: begin
        s_axi.r_valid = 1'b1;
        s_axi.r_id    = r_id_r;
        s_axi.r_data  = r_err_r ? {DATA_W{1'b0}} : mem_rdata;
        s_axi.r_resp  = r_err_r ? RESP_SLVERR : RESP_OKAY;
        s_axi.r_last  = (r_cnt_r == r_len_r);
        if (s_axi.r_ready) r_next_s = (r_cnt_r == r_len_r) ? R_IDLE : R_FETCH;
        else               r_next_s = R_DATA;
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read request latch and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_r    <= {ID_W{1'b0}};
      r_addr_r  <= {ADDR_W{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'b00;
      r_err_r   <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: if (s_axi.ar_valid) begin
          r_id_r    <= s_axi.ar_id;
          r_addr_r  <= s_axi.ar_addr;
          r_len_r   <= s_axi.ar_len;
          r_size_r  <= s_axi.ar_size;
          r_burst_r <= s_axi.ar_burst;
          r_cnt_r   <= 8'd0;
          r_err_r   <= r_illegal_s;
        end
        R_DATA: if (s_axi.r_ready && (r_cnt_r != r_len_r)) begin
          r_cnt_r  <= r_cnt_r + 8'd1;
          r_addr_r <= r_next_addr_s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench: stimulus pushes expected memory accesses and responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_burst_mem_slave;
  import axi_burst_mem_slave_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_burst_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = 64'd0;
  logic [7:0]        mem_wstrb;

  axi_burst_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .s_axi(bus),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        strb;
  } wr_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_re[$];
  logic [ID_W+1:0]   exp_b[$];
  rbeat_t            exp_r[$];

  int n_checks = 0;
  int n_pass   = 0;
  int r_hs_cnt = 0;

  wr_t                      mon_wr;
  rbeat_t                   mon_r;
  logic [ID_W+1:0]          mon_b;
  logic [ADDR_W-1:0]        mon_re;
  logic                     r_stalled_prev = 1'b0;
  logic [ID_W+DATA_W+3:0]   held_r = '0;
  logic                     pend_re = 1'b0;
  logic [ADDR_W-1:0]        pend_addr = 64'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic [ADDR_W-1:0] model_next(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    step = 64'd1 << size;
    return (burst == BURST_FIXED) ? a : ((a & ~(step - 64'd1)) + step);
  endfunction

  // Memory model: data appears the cycle after mem_re and holds until the next one
  always @(posedge clk) if (pend_re) mem_rdata <= mem_word(pend_addr);

  // Monitor: everything seen at negedge is what the next posedge commits
  always @(negedge clk) begin
    pend_re   <= mem_re;
    pend_addr <= mem_raddr;
    if (mem_we) begin
      if (exp_wr.size() == 0) check("unexpected_mem_we", 1'b1, 1'b0);
      else begin
        mon_wr = exp_wr.pop_front();
        check("mem_waddr", mem_waddr, mon_wr.addr);
        check("mem_wdata", mem_wdata, mon_wr.data);
        check("mem_wstrb", mem_wstrb, mon_wr.strb);
      end
    end
    if (mem_re) begin
      if (exp_re.size() == 0) check("unexpected_mem_re", 1'b1, 1'b0);
      else begin
        mon_re = exp_re.pop_front();
        check("mem_raddr", mem_raddr, mon_re);
      end
    end
    if (bus.b_valid && bus.b_ready) begin
      if (exp_b.size() == 0) check("unexpected_b", 1'b1, 1'b0);
      else begin
        mon_b = exp_b.pop_front();
        check("b_id_resp", {bus.b_id, bus.b_resp}, mon_b);
      end
    end
    if (bus.r_valid && bus.r_ready) begin
      r_hs_cnt <= r_hs_cnt + 1;
      if (exp_r.size() == 0) check("unexpected_r", 1'b1, 1'b0);
      else begin
        mon_r = exp_r.pop_front();
        check("r_data", bus.r_data, mon_r.data);
        check("r_id_resp_last", {bus.r_id, bus.r_resp, bus.r_last}, {mon_r.id, mon_r.resp, mon_r.last});
      end
    end
    if (bus.r_valid && r_stalled_prev)
      check("r_hold_stable", {bus.r_id, bus.r_data, bus.r_resp, bus.r_last}, held_r);
    r_stalled_prev <= bus.r_valid && !bus.r_ready;
    held_r         <= {bus.r_id, bus.r_data, bus.r_resp, bus.r_last};
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_ctl"},
          {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, mem_we, mem_re,
           bus.b_resp, bus.r_resp, bus.r_last, bus.b_id, bus.r_id},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 4'h0});
    check({name, "_data"}, bus.r_data | mem_wdata | mem_waddr | mem_raddr | {56'd0, mem_wstrb}, 64'd0);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input int nbeats, input logic [DATA_W-1:0] data0, input logic [7:0] strb);
    logic illegal;
    logic [ADDR_W-1:0] a;
    int guard;
    illegal = (size > 3'd3) || burst[1];
    a = addr;
    for (int i = 0; i < nbeats; i++) begin
      if (!illegal && i <= int'(len)) exp_wr.push_back('{a, data0 + 64'(i), strb});
      a = model_next(a, size, burst);
    end
    exp_b.push_back({id, (illegal || nbeats != int'(len) + 1) ? RESP_SLVERR : RESP_OKAY});
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
    bus.aw_valid = 1'b1;
    guard = 0;
    while (!bus.aw_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!bus.aw_ready) begin check("aw_timeout", 1'b0, 1'b1); bus.aw_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    check("w_ready_after_aw", bus.w_ready, 1'b1);
    for (int i = 0; i < nbeats; i++) begin
      bus.w_data = data0 + 64'(i); bus.w_strb = strb; bus.w_last = (i == nbeats - 1);
      bus.w_valid = 1'b1;
      guard = 0;
      while (!bus.w_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      if (!bus.w_ready) begin check("w_timeout", 1'b0, 1'b1); bus.w_valid = 1'b0; return; end
      @(posedge clk); #1;
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    check("b_valid_latency", bus.b_valid, 1'b1);
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic illegal;
    logic [ADDR_W-1:0] a;
    int guard;
    illegal = (size > 3'd3) || burst[1];
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (!illegal) exp_re.push_back(a);
      exp_r.push_back('{id, illegal ? 64'd0 : mem_word(a), illegal ? RESP_SLVERR : RESP_OKAY,
                        (i == int'(len))});
      a = model_next(a, size, burst);
    end
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
    bus.ar_valid = 1'b1;
    guard = 0;
    while (!bus.ar_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!bus.ar_ready) begin check("ar_timeout", 1'b0, 1'b1); bus.ar_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    check("mem_re_latency", mem_re, !illegal);
    @(posedge clk); #1;
    check("r_valid_latency", bus.r_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_wr.size() + exp_re.size() + exp_b.size() + exp_r.size() != 0 ||
            bus.b_valid || bus.r_valid) && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    check("drain", guard < 2000, 1'b1);
  endtask

  initial begin
    int base, guard;
    bus.aw_id = 4'h0; bus.aw_addr = 64'd0; bus.aw_len = 8'd0; bus.aw_size = 3'd0;
    bus.aw_burst = 2'b00; bus.aw_valid = 1'b0;
    bus.w_data = 64'd0; bus.w_strb = 8'h00; bus.w_last = 1'b0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b1;
    bus.ar_id = 4'h0; bus.ar_addr = 64'd0; bus.ar_len = 8'd0; bus.ar_size = 3'd0;
    bus.ar_burst = 2'b00; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    do_write(4'h3, 64'h0000_0000_8000_0008, 8'd0, 3'd3, BURST_INCR, 1, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    wait_idle();
    do_read(4'h5, 64'h0000_0000_8000_0000, 8'd3, 3'd3, BURST_INCR);
    wait_idle();
    do_write(4'h1, 64'h0000_0000_0000_1004, 8'd2, 3'd2, BURST_FIXED, 3, 64'h1111_2222_3333_4444, 8'hF0);
    wait_idle();
    do_read(4'h2, 64'h0000_0000_0000_2000, 8'd1, 3'd3, BURST_WRAP);
    wait_idle();
    do_write(4'h6, 64'h0000_0000_0000_3000, 8'd3, 3'd3, BURST_INCR, 2, 64'hAAAA_0000_0000_0001, 8'hFF);
    wait_idle();
    do_write(4'h7, 64'h0000_0000_0000_4000, 8'd0, 3'd4, BURST_INCR, 1, 64'h5555_0000_0000_0000, 8'hFF);
    wait_idle();
    do_read(4'h8, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, BURST_INCR);
    wait_idle();
    do_read(4'h9, 64'h0000_0000_0000_1003, 8'd1, 3'd2, BURST_INCR);
    wait_idle();

    // simultaneous AW/AR while R is back-pressured
    fork
      do_write(4'hA, 64'h0000_0000_0000_5000, 8'd1, 3'd3, BURST_INCR, 2, 64'h0BAD_F00D_0000_0010, 8'h0F);
      do_read(4'hB, 64'h0000_0000_0000_6000, 8'd1, 3'd3, BURST_INCR);
      begin
        bus.r_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.r_ready = 1'b1;
      end
    join
    wait_idle();

    do_read(4'hC, 64'h0000_0000_0000_0000, 8'd255, 3'd3, BURST_INCR);
    wait_idle();

    base = r_hs_cnt;
    do_read(4'hD, 64'h0000_0000_0000_7000, 8'd7, 3'd3, BURST_INCR);
    guard = 0;
    while (r_hs_cnt < base + 2 && guard < 100) begin @(posedge clk); guard++; end
    check("reset_beat_wait", guard < 100, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_idle_outputs("mid_reset");
    exp_r.delete();
    exp_re.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    do_read(4'hE, 64'h0000_0000_0000_7100, 8'd1, 3'd3, BURST_INCR);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

Parametrised AXI4 slave memory model with INCR/FIXED burst support. It sits between the core's AXI interconnect and the simulation RAM. It converts each AXI burst into single-beat accesses on a simple memory port, with independent read and write engines. It also returns SLVERR for transfers it does not support.

## Interface
Parameters:
- DATA_W, 64: AXI and memory data width; must be 32 or 64.
- ADDR_W, 64: address width.
- ID_W, 4: AXI ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- s_axi_aw_id/addr/len/size/burst  in  ID_W/ADDR_W/8/3/2  write address payload.
- s_axi_aw_valid / s_axi_aw_ready  in/out  1/1  write address handshake.
- s_axi_w_data/strb/last  in  DATA_W/DATA_W/8/1  write data payload.
- s_axi_w_valid / s_axi_w_ready  in/out  1/1  write data handshake.
- s_axi_b_id/resp  out  ID_W/2  write response payload.
- s_axi_b_valid / s_axi_b_ready  out/in  1/1  write response handshake.
- s_axi_ar_id/addr/len/size/burst  in  ID_W/ADDR_W/8/3/2  read address payload.
- s_axi_ar_valid / s_axi_ar_ready  in/out  1/1  read address handshake.
- s_axi_r_id/data/resp/last  out  ID_W/DATA_W/2/1  read data payload.
- s_axi_r_valid / s_axi_r_ready  out/in  1/1  read data handshake.
- mem_we/mem_waddr/mem_wdata/mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  memory write port.
- mem_re/mem_raddr  out  1/ADDR_W  memory read request.
- mem_rdata  in  DATA_W  read data. Valid the cycle after mem_re and held stable until the next mem_re.

## Operation
**Write engine** (states W_IDLE, W_DATA, W_RESP):
- W_IDLE: aw_ready=1. On the AW handshake, latch id, addr, len, size and burst; clear the beat counter; set the error flag if the request is illegal; go to W_DATA.
- W_DATA: w_ready=1.
  - Each W handshake pulses mem_we in the same cycle, carrying the current beat address, w_data and w_strb. The pulse is suppressed when the error flag is set.
  - After each beat, increment the counter and advance the address.
  - When w_last=1, go to W_RESP. If w_last does not coincide with counter==len, set the error flag.
- W_RESP: b_valid=1; b_id is the latched id; b_resp is OKAY (00) or SLVERR (10). The B handshake returns the engine to W_IDLE.

**Read engine** (states R_IDLE, R_FETCH, R_DATA):
- R_IDLE: ar_ready=1. On the AR handshake, latch the request and go to R_FETCH.
- R_FETCH: pulse mem_re with the beat address for one cycle (suppressed on error); go to R_DATA.
- R_DATA: r_valid=1.
  - r_data is mem_rdata, or 0 on error.
  - r_resp is OKAY or SLVERR; r_id is the latched id; r_last = (counter==len).
  - On the R handshake: if r_last, go to R_IDLE; otherwise increment the counter, advance the address and go to R_FETCH.

**Illegal requests:**
- size > log2(DATA_W/8).
- burst==WRAP (10) or reserved (11).
- An illegal read still returns len+1 beats, all SLVERR.

**Address advance:**
- FIXED: the address is held.
- INCR: next = (addr & ~(2^size-1)) + 2^size, computed modulo 2^ADDR_W.
- 4 KB boundary crossing is not checked.

**Concurrency:** the two engines are fully independent. Simultaneous AW and AR are both accepted, and mem_we and mem_re may pulse in the same cycle.

## Timing
- Reset values:
  - States W_IDLE and R_IDLE, so aw_ready=ar_ready=1.
  - All other outputs 0.
  - Latched fields and counters 0.
- Reset asserted mid-burst aborts the burst immediately; no B or R response is produced.
- Write latency:
  - AW handshake at cycle T; w_ready from T+1.
  - Single-beat write: W handshake at T+1, b_valid at T+2.
- Read latency:
  - AR handshake at T; mem_re at T+1; r_valid at T+2.
  - Each subsequent beat takes 2 cycles after the prior R handshake; maximum throughput is 1 beat per 2 cycles.
- Back-pressure:
  - b_valid, r_valid and the R payload hold stable until their handshake completes.
  - AW and AR are not accepted again until the engine is back in IDLE; there is no outstanding-transaction queue.
- len=255: the 8-bit counter reaches 255 without wrapping, and r_last asserts on beat 256.

## Structure
- Shared package: state encodings W_IDLE/W_DATA/W_RESP and R_IDLE/R_FETCH/R_DATA; RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; BURST_FIXED/INCR/WRAP constants.
- Sub-module axi_beat_addr_gen, instantiated twice (once per engine). Inputs: addr, size, burst. Outputs: next_addr and an illegal flag.

## Test plan
- Single-beat write: AW addr=0x80000008, len=0, size=3, INCR, w_data=0xDEADBEEF_01234567, strb=0xFF. Expect mem_we one cycle with waddr=0x80000008; then b_resp=00 with the matching id.
- INCR read: AR addr=0x80000000, len=3, size=3, id=5. Expect mem_raddr 0x...00, 0x...08, 0x...10, 0x...18; four R beats with id=5; r_last only on the 4th beat.
- FIXED write: len=2, size=2, addr=0x1004, DATA_W=64. Expect three mem_we pulses, all with waddr=0x1004 and the strb passed through.
- Errors:
  - WRAP read, len=1: expect two beats with r_resp=10, r_data=0 and no mem_re.
  - Write with w_last on beat 1 while len=3: expect b_resp=10.
- Concurrency and back-pressure: AW and AR in the same cycle, with r_ready held low for 5 cycles. Both complete; r_data stays stable while stalled; b_ready is independent.
- Reset mid-burst: assert rst during beat 2 of a len=7 read. All outputs go to 0, ar_ready=1, and a new read after release starts clean.
